log_lane_spawner: RTL and testbench

- Generates and moves the log objects for one river lane, one frame step per startOfFrame.
- Answers per-pixel drawing queries from the VGA scan with a per-log draw-request vector. The game controller's collision logic consumes that vector.
- One instance per lane; the top level concatenates the draw-request vectors from all lanes into the controller's wide logs_draw_req bus.

---
 rtl/log_lane_spawner.sv | 163 ++++++++++++++++
 tb/tb_log_lane_spawner.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_lane_spawner.sv
// River-lane log generator: moves, retires and spawns logs once per frame and answers pixel draw queries.
// Latency: frame update takes 3 cycles after startOfFrame; draw outputs are registered, 1 cycle after pixelX/pixelY.
// Backpressure: none; startOfFrame pulses outside the idle state are dropped, enable=0 parks the FSM in WAIT.
module log_lane_spawner #(
    parameter int         N_LOGS    = 4,
    parameter int         LOG_W     = 96,
    parameter int         LOG_H     = 32,
    parameter int         LANE_Y    = 128,
    parameter int         SPEED     = 2,
    parameter bit         DIR_RIGHT = 1'b1,
    parameter int         SCREEN_W  = 640,
    parameter int         MIN_GAP   = 30,
    parameter int         GAP_MASK  = 31,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enable,
    input  logic              startOfFrame,
    input  logic [10:0]       pixelX,
    input  logic [10:0]       pixelY,
    output logic [N_LOGS-1:0] draw_req,
    output logic              any_draw_req,
    output logic [10:0]       offsetX,
    output logic [10:0]       offsetY,
    output logic [N_LOGS-1:0] active_mask,
    output logic [2:0]        log_count
);

    localparam int IW = (N_LOGS > 1) ? $clog2(N_LOGS) : 1;

    localparam logic signed [11:0] SPAWN_X     = DIR_RIGHT ? 12'(-LOG_W) : 12'(SCREEN_W);
    localparam logic signed [11:0] RIGHT_LIMIT = 12'(SCREEN_W);
    localparam logic signed [11:0] LEFT_LIMIT  = 12'(-LOG_W);
    localparam logic signed [11:0] STEP        = 12'(SPEED);
    localparam logic signed [12:0] WIDTH13     = 13'(LOG_W);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_MOVE   = 2'd1,
        S_RETIRE = 2'd2,
        S_SPAWN  = 2'd3
    } state_t;

    state_t             state;
    logic signed [11:0] xpos [N_LOGS];
    logic [N_LOGS-1:0]  active;
    logic [15:0]        spawn_timer;
    logic [7:0]         lfsr;
    logic [7:0]         lfsr_next;

    logic               free_found;
    logic [IW-1:0]      free_idx;

    logic signed [12:0] px_s;
    logic               y_in;
    logic [N_LOGS-1:0]  hit;
    logic [10:0]        first_off;

    // Sign-extend a position so x + LOG_W never wraps.
    function automatic logic signed [12:0] sext(input logic signed [11:0] v);
        return {v[11], v};
    endfunction

    // Polynomial x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    assign lfsr_next   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign active_mask = active;

    assign px_s = signed'({2'b00, pixelX});
    assign y_in = ({1'b0, pixelY} >= 12'(LANE_Y)) && ({1'b0, pixelY} < 12'(LANE_Y + LOG_H));

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_LOGS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Per-slot hit test; offset follows the lowest-index hit.
    always_comb begin
        hit       = '0;
        first_off = '0;
        for (int i = N_LOGS - 1; i >= 0; i--) begin
            hit[i] = active[i] && y_in &&
                     (sext(xpos[i]) <= px_s) && (px_s < sext(xpos[i]) + WIDTH13);
            if (hit[i]) begin
                first_off = 11'(px_s - sext(xpos[i]));
            end
        end
    end

    // Registered draw answer and occupancy count.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            draw_req     <= '0;
            any_draw_req <= 1'b0;
            offsetX      <= '0;
            offsetY      <= '0;
            log_count    <= '0;
        end else begin
            draw_req     <= hit;
            any_draw_req <= |hit;
            offsetX      <= (|hit) ? first_off : 11'd0;
            offsetY      <= (|hit) ? 11'(pixelY - 11'(LANE_Y)) : 11'd0;
            log_count    <= 3'($countones(active));
        end
    end

    // Frame sequencer: WAIT -> MOVE -> RETIRE -> SPAWN -> WAIT.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state       <= S_WAIT;
            active      <= '0;
            spawn_timer <= '0;
            lfsr        <= LFSR_SEED;
            for (int i = 0; i < N_LOGS; i++) begin
                xpos[i] <= '0;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (startOfFrame && enable) begin
                        state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    for (int i = 0; i < N_LOGS; i++) begin
                        if (active[i]) begin
                            xpos[i] <= DIR_RIGHT ? (xpos[i] + STEP) : (xpos[i] - STEP);
                        end
                    end
                    state <= S_RETIRE;
                end
                S_RETIRE: begin
                    for (int i = 0; i < N_LOGS; i++) begin
                        if (DIR_RIGHT ? (xpos[i] >= RIGHT_LIMIT) : (xpos[i] <= LEFT_LIMIT)) begin
                            active[i] <= 1'b0;
                        end
                    end
                    state <= S_SPAWN;
                end
                S_SPAWN: begin
                    lfsr <= lfsr_next;
                    if (spawn_timer != 16'd0) begin
                        spawn_timer <= spawn_timer - 16'd1;
                    end else if (free_found) begin
                        active[free_idx] <= 1'b1;
                        xpos[free_idx]   <= SPAWN_X;
                        spawn_timer      <= 16'(MIN_GAP) + 16'(lfsr_next & 8'(GAP_MASK));
                    end
                    state <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_log_lane_spawner.sv
// Bench for log_lane_spawner: two lanes (random gap and fixed gap) against a frame-level model.
// Latency: frame = 5 clocks from startOfFrame to settled log_count; draw queries sampled 1 clock later.
// Backpressure: none; stimulus is open-loop with fixed cycle budgets.
module tb_log_lane_spawner;

    localparam int LW = 96;
    localparam int LH = 32;
    localparam int LY = 128;
    localparam int SW = 640;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;

    logic [3:0]  draw_req     [2];
    logic        any_draw_req [2];
    logic [10:0] offsetX      [2];
    logic [10:0] offsetY      [2];
    logic [3:0]  active_mask  [2];
    logic [2:0]  log_count    [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int frame_no = 0;

    // Frame-level reference: positions, occupancy, gap timer and LFSR per lane.
    int         mx     [2][4];
    bit         mact   [2][4];
    int         mtimer [2];
    logic [7:0] mlfsr  [2];
    int         gapmask[2] = '{31, 0};

    always #5 clk = ~clk;

    log_lane_spawner u_dut0 (
        .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .draw_req(draw_req[0]), .any_draw_req(any_draw_req[0]),
        .offsetX(offsetX[0]), .offsetY(offsetY[0]),
        .active_mask(active_mask[0]), .log_count(log_count[0])
    );

    log_lane_spawner #(.GAP_MASK(0)) u_dut1 (
        .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .draw_req(draw_req[1]), .any_draw_req(any_draw_req[1]),
        .offsetX(offsetX[1]), .offsetY(offsetY[1]),
        .active_mask(active_mask[1]), .log_count(log_count[1])
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                mx[m][i]   = 0;
                mact[m][i] = 1'b0;
            end
            mtimer[m] = 0;
            mlfsr[m]  = 8'hA5;
        end
    endfunction

    // One enabled frame: move right by 2, drop logs past the screen edge, then maybe spawn.
    function automatic void model_frame();
        int slot;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) if (mact[m][i]) mx[m][i] += 2;
            for (int i = 0; i < 4; i++) if (mact[m][i] && mx[m][i] >= SW) mact[m][i] = 1'b0;
            mlfsr[m] = lfsr_step(mlfsr[m]);
            if (mtimer[m] > 0) begin
                mtimer[m]--;
            end else begin
                slot = -1;
                for (int i = 3; i >= 0; i--) if (!mact[m][i]) slot = i;
                if (slot >= 0) begin
                    mact[m][slot] = 1'b1;
                    mx[m][slot]   = -LW;
                    mtimer[m]     = 30 + int'(mlfsr[m] & 8'(gapmask[m]));
                end
            end
        end
    endfunction

    function automatic logic [3:0] model_mask(input int m);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = mact[m][i];
        return r;
    endfunction

    function automatic int model_count(input int m);
        int c = 0;
        for (int i = 0; i < 4; i++) if (mact[m][i]) c++;
        return c;
    endfunction

    function automatic void model_draw(input int m, input int px, input int py,
                                       output logic [3:0] dr, output logic [10:0] ox,
                                       output logic [10:0] oy);
        dr = '0; ox = '0; oy = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mact[m][i] && mx[m][i] <= px && px < mx[m][i] + LW && py >= LY && py < LY + LH) begin
                dr[i] = 1'b1;
                ox    = 11'(px - mx[m][i]);
                oy    = 11'(py - LY);
            end
        end
    endfunction

    // Pixel near a random live log edge of lane 0, or anywhere if the lane is empty.
    function automatic int pick_px();
        int i = $urandom_range(0, 3);
        int p;
        if (mact[0][i]) p = mx[0][i] + $urandom_range(0, LW + 3) - 2;
        else            p = $urandom_range(0, 700);
        if (p < 0) p = 0;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input logic en);
        enable       = en;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (4) tick();
        if (en) begin
            model_frame();
            frame_no++;
        end
    endtask

    task automatic query(input int px, input int py);
        pixelX = 11'(px);
        pixelY = 11'(py);
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b1; enable = 1'b0; startOfFrame = 1'b0;
        pixelX = 11'd10; pixelY = 11'd130;
        model_reset();
        repeat (3) tick();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (draw_req[m] !== 4'b0 || any_draw_req[m] !== 1'b0 || offsetX[m] !== 11'd0 ||
                offsetY[m] !== 11'd0 || active_mask[m] !== 4'b0 || log_count[m] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset%0d: got dr=%b any=%b ox=%0d oy=%0d mask=%b cnt=%0d, expected all zero",
                         m, draw_req[m], any_draw_req[m], offsetX[m], offsetY[m], active_mask[m], log_count[m]);
            end
        end
        resetN = 1'b0;
        tick();
    endtask

    task automatic test_first_spawn();
        do_frame(1'b1);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (active_mask[m] !== 4'b0001 || log_count[m] !== 3'd1) begin
                n_fail++;
                $display("FAIL first_spawn%0d: got mask=%b cnt=%0d, expected mask=0001 cnt=1",
                         m, active_mask[m], log_count[m]);
            end
        end
        // Freshly spawned log sits at -96: pixel 0 is just past its right edge.
        query(0, 128);
        n_cmp++;
        if (draw_req[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL spawn_x: got dr=%b, expected 0000", draw_req[0]);
        end
        do_frame(1'b1);
        query(0, 128);
        n_cmp++;
        if (draw_req[0] !== 4'b0001 || any_draw_req[0] !== 1'b1 || offsetX[0] !== 11'd94 || offsetY[0] !== 11'd0) begin
            n_fail++;
            $display("FAIL step1_hit: got dr=%b any=%b ox=%0d oy=%0d, expected dr=0001 any=1 ox=94 oy=0",
                     draw_req[0], any_draw_req[0], offsetX[0], offsetY[0]);
        end
        query(2, 128);
        n_cmp++;
        if (draw_req[0] !== 4'b0000 || any_draw_req[0] !== 1'b0 || offsetX[0] !== 11'd0) begin
            n_fail++;
            $display("FAIL step1_xedge: got dr=%b any=%b ox=%0d, expected dr=0000 any=0 ox=0",
                     draw_req[0], any_draw_req[0], offsetX[0]);
        end
        query(0, 160);
        n_cmp++;
        if (draw_req[0] !== 4'b0000 || offsetY[0] !== 11'd0) begin
            n_fail++;
            $display("FAIL step1_yedge: got dr=%b oy=%0d, expected dr=0000 oy=0", draw_req[0], offsetY[0]);
        end
    endtask

    task automatic test_long_run();
        int second0 = -1;
        int second1 = -1;
        logic [3:0]  e_dr;
        logic [10:0] e_ox, e_oy;
        int px, py;
        while (frame_no < 372) begin
            do_frame(1'b1);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (active_mask[m] !== model_mask(m) || int'(log_count[m]) != model_count(m)) begin
                    n_fail++;
                    $display("FAIL run_mask%0d frame %0d: got mask=%b cnt=%0d, expected mask=%b cnt=%0d",
                             m, frame_no, active_mask[m], log_count[m], model_mask(m), model_count(m));
                end
            end
            if (second0 < 0 && active_mask[0][1] === 1'b1) second0 = frame_no;
            if (second1 < 0 && active_mask[1][1] === 1'b1) second1 = frame_no;
            for (int q = 0; q < 2; q++) begin
                px = pick_px();
                py = $urandom_range(LY - 3, LY + LH + 2);
                query(px, py);
                for (int m = 0; m < 2; m++) begin
                    model_draw(m, px, py, e_dr, e_ox, e_oy);
                    n_cmp++;
                    if (draw_req[m] !== e_dr || any_draw_req[m] !== (|e_dr) || offsetX[m] !== e_ox || offsetY[m] !== e_oy) begin
                        n_fail++;
                        $display("FAIL run_query%0d frame %0d px=%0d py=%0d: got dr=%b any=%b ox=%0d oy=%0d, expected dr=%b ox=%0d oy=%0d",
                                 m, frame_no, px, py, draw_req[m], any_draw_req[m], offsetX[m], offsetY[m], e_dr, e_ox, e_oy);
                    end
                end
            end
            // Fixed-gap lane: slot0 reaches 638, then retires at 640 and respawns in the same frame.
            if (frame_no == 368) begin
                query(639, 130);
                n_cmp++;
                if (draw_req[1][0] !== 1'b1 || offsetX[1] !== 11'd1) begin
                    n_fail++;
                    $display("FAIL pre_retire: got dr=%b ox=%0d, expected bit0=1 ox=1", draw_req[1], offsetX[1]);
                end
            end
            if (frame_no == 369) begin
                query(639, 130);
                n_cmp++;
                if (active_mask[1] !== 4'b1111 || draw_req[1][0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL retire_respawn: got mask=%b dr=%b, expected mask=1111 bit0=0", active_mask[1], draw_req[1]);
                end
            end
            if (frame_no == 370) begin
                query(0, 128);
                n_cmp++;
                if (draw_req[1][0] !== 1'b1 || offsetX[1] !== 11'd94) begin
                    n_fail++;
                    $display("FAIL respawn_slot0: got dr=%b ox=%0d, expected bit0=1 ox=94", draw_req[1], offsetX[1]);
                end
            end
        end
        n_cmp++;
        if (second0 < 32 || second0 > 63) begin
            n_fail++;
            $display("FAIL gap_random: second spawn at frame %0d, expected 32..63", second0);
        end
        n_cmp++;
        if (second1 != 32) begin
            n_fail++;
            $display("FAIL gap_fixed: second spawn at frame %0d, expected 32", second1);
        end
    endtask

    task automatic test_disable();
        logic [3:0]  e_dr;
        logic [10:0] e_ox, e_oy;
        int px, py;
        for (int f = 0; f < 10; f++) do_frame(1'b0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (active_mask[m] !== model_mask(m) || int'(log_count[m]) != model_count(m)) begin
                n_fail++;
                $display("FAIL disable_mask%0d: got mask=%b cnt=%0d, expected mask=%b cnt=%0d",
                         m, active_mask[m], log_count[m], model_mask(m), model_count(m));
            end
        end
        for (int q = 0; q < 6; q++) begin
            px = pick_px();
            py = $urandom_range(LY - 2, LY + LH + 1);
            query(px, py);
            for (int m = 0; m < 2; m++) begin
                model_draw(m, px, py, e_dr, e_ox, e_oy);
                n_cmp++;
                if (draw_req[m] !== e_dr || offsetX[m] !== e_ox || offsetY[m] !== e_oy) begin
                    n_fail++;
                    $display("FAIL disable_query%0d px=%0d py=%0d: got dr=%b ox=%0d oy=%0d, expected dr=%b ox=%0d oy=%0d",
                             m, px, py, draw_req[m], offsetX[m], offsetY[m], e_dr, e_ox, e_oy);
                end
            end
        end
    endtask

    task automatic test_sof_during_move();
        logic [3:0]  e_dr;
        logic [10:0] e_ox, e_oy;
        int px, py;
        enable = 1'b1;
        startOfFrame = 1'b1;
        tick();
        tick();
        startOfFrame = 1'b0;
        repeat (4) tick();
        model_frame();
        frame_no++;
        for (int q = 0; q < 6; q++) begin
            px = pick_px();
            py = $urandom_range(LY, LY + LH - 1);
            query(px, py);
            for (int m = 0; m < 2; m++) begin
                model_draw(m, px, py, e_dr, e_ox, e_oy);
                n_cmp++;
                if (draw_req[m] !== e_dr || offsetX[m] !== e_ox || offsetY[m] !== e_oy) begin
                    n_fail++;
                    $display("FAIL single_step%0d px=%0d py=%0d: got dr=%b ox=%0d oy=%0d, expected dr=%b ox=%0d oy=%0d",
                             m, px, py, draw_req[m], offsetX[m], offsetY[m], e_dr, e_ox, e_oy);
                end
            end
        end
    endtask

    task automatic test_reset_mid_retire();
        pixelX = 11'd600; pixelY = 11'd140;
        enable = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        resetN = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (draw_req[m] !== 4'b0 || any_draw_req[m] !== 1'b0 || offsetX[m] !== 11'd0 ||
                offsetY[m] !== 11'd0 || active_mask[m] !== 4'b0 || log_count[m] !== 3'd0) begin
                n_fail++;
                $display("FAIL mid_reset%0d: got dr=%b any=%b ox=%0d oy=%0d mask=%b cnt=%0d, expected all zero",
                         m, draw_req[m], any_draw_req[m], offsetX[m], offsetY[m], active_mask[m], log_count[m]);
            end
        end
        tick();
        resetN = 1'b0;
        model_reset();
        tick();
        do_frame(1'b1);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (active_mask[m] !== 4'b0001 || log_count[m] !== 3'd1) begin
                n_fail++;
                $display("FAIL post_reset_spawn%0d: got mask=%b cnt=%0d, expected mask=0001 cnt=1",
                         m, active_mask[m], log_count[m]);
            end
        end
        do_frame(1'b1);
        query(1, 159);
        n_cmp++;
        if (draw_req[0] !== 4'b0001 || offsetX[0] !== 11'd95 || offsetY[0] !== 11'd31) begin
            n_fail++;
            $display("FAIL post_reset_pos: got dr=%b ox=%0d oy=%0d, expected dr=0001 ox=95 oy=31",
                     draw_req[0], offsetX[0], offsetY[0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_long_run();
        test_disable();
        test_sof_during_move();
        test_reset_mid_retire();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
